// File: rtl/pc_fetch_sequencer_if.sv
// Instruction-memory fetch bus shared by the fetch sequencer and the
// instruction memory. The sequencer drives the request and address; the
// memory answers with an acknowledge and the instruction word.
interface pc_fetch_sequencer_if;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck;
  logic [31:0] imemRdata;

  // Sequencer side of the fetch bus
  modport master (
    output imemReq,
    output imemAddr,
    input  imemAck,
    input  imemRdata
  );

  // Instruction-memory side of the fetch bus
  modport slave (
    input  imemReq,
    input  imemAddr,
    output imemAck,
    output imemRdata
  );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer
// Owns the program counter, runs the req/ack instruction fetch at the
// current PC, holds the fetched word for execute and picks the next PC with
// priority halt > jump > branch > PC+PC_STEP. A fetch that sees no ack for
// WAIT_LIMIT cycles sets a sticky fault and parks the sequencer in HALT.
// Optional feature macro: PC_TRAP_EN -- a misaligned jump/branch target is
// replaced by TRAP_VECTOR and trap pulses for one cycle. Without the macro,
// targets are loaded as given and trap stays 0.
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned PC_STEP      = 4,
  parameter int unsigned WAIT_LIMIT   = 16,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_start,
  input  logic                         i_stall,
  input  logic                         i_haltReq,
  input  logic                         i_jump,
  input  logic [31:0]                  i_jumpTarget,
  input  logic                         i_branchTaken,
  input  logic [31:0]                  i_branchTarget,
  pc_fetch_sequencer_if.master         imemBus,
  output logic [31:0]                  o_pcOut,
  output logic [31:0]                  o_instr,
  output logic                         o_instrValid,
  output logic                         o_halted,
  output logic                         o_fault,
  output logic [31:0]                  o_retireCount,
  output logic                         o_trap
);

  // The wait counter only has to reach WAIT_LIMIT-1; a limit of 1 still
  // needs a one-bit counter.
  localparam int unsigned CW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
  localparam logic [CW-1:0] LIMIT_M1 = CW'(WAIT_LIMIT - 1);
  localparam logic [31:0] STEP = 32'(PC_STEP);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } seqState_t;

  seqState_t      r_state;
  logic [31:0]    r_pc;
  logic [31:0]    r_instr;
  logic           r_imemReq;
  logic           r_instrValid;
  logic           r_halted;
  logic           r_fault;
  logic [31:0]    r_retireCount;
  logic           r_trap;
  logic [CW-1:0]  r_waitCount;

  logic           w_redirect;
  logic [31:0]    w_redirTarget;
  logic           w_trapHit;
  logic [31:0]    w_redirPc;

  // Pick the redirect target (jump beats branch) and decide whether it traps
  always_comb begin
    w_redirect    = i_jump | i_branchTaken;
    w_redirTarget = i_jump ? i_jumpTarget : i_branchTarget;
`ifdef PC_TRAP_EN
    w_trapHit     = w_redirect & (w_redirTarget[1:0] != 2'b00);
`else
    w_trapHit     = 1'b0;
`endif
    w_redirPc     = w_trapHit ? TRAP_VECTOR : w_redirTarget;
  end

  // Sequencer FSM with every output registered; async reset clears the
  // request the moment reset asserts, even in the middle of a fetch
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= IDLE;
      r_pc          <= RESET_VECTOR;
      r_instr       <= 32'h0;
      r_imemReq     <= 1'b0;
      r_instrValid  <= 1'b0;
      r_halted      <= 1'b0;
      r_fault       <= 1'b0;
      r_retireCount <= 32'h0;
      r_trap        <= 1'b0;
      r_waitCount   <= '0;
    end else begin
      r_trap <= 1'b0;
      case (r_state)
        IDLE, HALT: begin
          if (i_start) begin
            r_state     <= FETCH;
            r_imemReq   <= 1'b1;
            r_halted    <= 1'b0;
            r_waitCount <= '0;
          end
        end
        FETCH: begin
          if (imemBus.imemAck) begin
            r_instr      <= imemBus.imemRdata;
            r_waitCount  <= '0;
            r_state      <= EXEC;
            r_imemReq    <= 1'b0;
            r_instrValid <= 1'b1;
          end else if (r_waitCount == LIMIT_M1) begin
            r_fault     <= 1'b1;
            r_state     <= HALT;
            r_imemReq   <= 1'b0;
            r_halted    <= 1'b1;
            r_waitCount <= '0;
          end else begin
            r_waitCount <= r_waitCount + 1'b1;
          end
        end
        EXEC: begin
          if (!i_stall) begin
            r_retireCount <= r_retireCount + 32'd1;
            r_instrValid  <= 1'b0;
            if (i_haltReq) begin
              r_pc     <= r_pc + STEP;
              r_state  <= HALT;
              r_halted <= 1'b1;
            end else begin
              r_state   <= FETCH;
              r_imemReq <= 1'b1;
              if (w_redirect) begin
                r_pc   <= w_redirPc;
                r_trap <= w_trapHit;
              end else begin
                r_pc <= r_pc + STEP;
              end
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Registered state straight onto the ports; fetch address is always the PC
  assign imemBus.imemReq  = r_imemReq;
  assign imemBus.imemAddr = r_pc;
  assign o_pcOut          = r_pc;
  assign o_instr          = r_instr;
  assign o_instrValid     = r_instrValid;
  assign o_halted         = r_halted;
  assign o_fault          = r_fault;
  assign o_retireCount    = r_retireCount;
  assign o_trap           = r_trap;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer. Every expected value below is
// worked out by hand from the sequencer's behaviour; the PC_TRAP_EN macro
// selects which redirect result is expected for a misaligned branch target.
module tb_pc_fetch_sequencer;

  logic        clk;
  logic        rstN;
  logic        start;
  logic        stall;
  logic        haltReq;
  logic        jump;
  logic [31:0] jumpTarget;
  logic        branchTaken;
  logic [31:0] branchTarget;
  logic [31:0] pcOut;
  logic [31:0] instr;
  logic        instrValid;
  logic        halted;
  logic        fault;
  logic [31:0] retireCount;
  logic        trap;

  int compareCount  = 0;
  int mismatchCount = 0;

  logic [31:0] expTrapPc;
  logic        expTrap;

  pc_fetch_sequencer_if imemBus();

  pc_fetch_sequencer dut (
    .i_clk          (clk),
    .i_rst_n        (rstN),
    .i_start        (start),
    .i_stall        (stall),
    .i_haltReq      (haltReq),
    .i_jump         (jump),
    .i_jumpTarget   (jumpTarget),
    .i_branchTaken  (branchTaken),
    .i_branchTarget (branchTarget),
    .imemBus        (imemBus.master),
    .o_pcOut        (pcOut),
    .o_instr        (instr),
    .o_instrValid   (instrValid),
    .o_halted       (halted),
    .o_fault        (fault),
    .o_retireCount  (retireCount),
    .o_trap         (trap)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value against its hand-computed expectation
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, let a rising edge pass, settle 1 ns after it
  task automatic applyStimulus(input logic st, input logic sl, input logic hr,
                               input logic jp, input logic [31:0] jt,
                               input logic br, input logic [31:0] bt,
                               input logic ack, input logic [31:0] rdata);
    start             = st;
    stall             = sl;
    haltReq           = hr;
    jump              = jp;
    jumpTarget        = jt;
    branchTaken       = br;
    branchTarget      = bt;
    imemBus.imemAck   = ack;
    imemBus.imemRdata = rdata;
    @(posedge clk);
    #1;
  endtask

  // Directed scenario walk-through, ending in the summary line
  initial begin
`ifdef PC_TRAP_EN
    expTrapPc = 32'h0000_0100;
    expTrap   = 1'b1;
`else
    expTrapPc = 32'h0000_0102;
    expTrap   = 1'b0;
`endif
    rstN              = 1'b0;
    start             = 1'b0;
    stall             = 1'b0;
    haltReq           = 1'b0;
    jump              = 1'b0;
    jumpTarget        = 32'h0;
    branchTaken       = 1'b0;
    branchTarget      = 32'h0;
    imemBus.imemAck   = 1'b0;
    imemBus.imemRdata = 32'h0;

    #1;
    checkOutput("rst_pc",     pcOut, 32'h0);
    checkOutput("rst_instr",  instr, 32'h0);
    checkOutput("rst_req",    32'(imemBus.imemReq), 32'd0);
    checkOutput("rst_valid",  32'(instrValid), 32'd0);
    checkOutput("rst_halted", 32'(halted), 32'd0);
    checkOutput("rst_fault",  32'(fault), 32'd0);
    checkOutput("rst_retire", retireCount, 32'd0);
    checkOutput("rst_trap",   32'(trap), 32'd0);
    #3 rstN = 1'b1;

    // Sequential fetch: addresses 0,4,8,C with one-cycle ack
    applyStimulus(1, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("seq_req",  32'(imemBus.imemReq), 32'd1);
      checkOutput("seq_addr", imemBus.imemAddr, 32'(i * 4));
      applyStimulus(0, 0, 0, 0, 32'h0, 0, 32'h0, 1, 32'hA000_0000 + 32'(i));
      checkOutput("seq_valid", 32'(instrValid), 32'd1);
      checkOutput("seq_instr", instr, 32'hA000_0000 + 32'(i));
      applyStimulus(0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    end
    checkOutput("seq_retire", retireCount, 32'd4);
    checkOutput("seq_pc",     pcOut, 32'h10);

    // Stall for 3 cycles with a jump pending, then release the jump
    applyStimulus(0, 0, 0, 0, 32'h0, 0, 32'h0, 1, 32'hB000_0000);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 0, 1, 32'h40, 0, 32'h0, 0, 32'h0);
      checkOutput("stall_retire", retireCount, 32'd4);
      checkOutput("stall_pc",     pcOut, 32'h10);
      checkOutput("stall_valid",  32'(instrValid), 32'd1);
    end
    applyStimulus(0, 0, 0, 1, 32'h40, 0, 32'h0, 0, 32'h0);
    checkOutput("jump_addr",   imemBus.imemAddr, 32'h40);
    checkOutput("jump_retire", retireCount, 32'd5);
    checkOutput("jump_req",    32'(imemBus.imemReq), 32'd1);

    // Jump and branch together: jump wins; then a lone branch
    applyStimulus(0, 0, 0, 0, 32'h0, 0, 32'h0, 1, 32'hC000_0000);
    applyStimulus(0, 0, 0, 1, 32'h80, 1, 32'h90, 0, 32'h0);
    checkOutput("jb_pc",     pcOut, 32'h80);
    checkOutput("jb_retire", retireCount, 32'd6);
    applyStimulus(0, 0, 0, 0, 32'h0, 0, 32'h0, 1, 32'hC000_0001);
    applyStimulus(0, 0, 0, 0, 32'h0, 1, 32'h90, 0, 32'h0);
    checkOutput("br_pc",     pcOut, 32'h90);
    checkOutput("br_retire", retireCount, 32'd7);

    // Fetch timeout: 15 silent cycles are fine, the 16th faults
    repeat (15) applyStimulus(0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    checkOutput("wait_req",   32'(imemBus.imemReq), 32'd1);
    checkOutput("wait_fault", 32'(fault), 32'd0);
    applyStimulus(0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    checkOutput("to_fault",  32'(fault), 32'd1);
    checkOutput("to_halted", 32'(halted), 32'd1);
    checkOutput("to_req",    32'(imemBus.imemReq), 32'd0);
    checkOutput("to_pc",     pcOut, 32'h90);
    applyStimulus(1, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    checkOutput("refetch_req",    32'(imemBus.imemReq), 32'd1);
    checkOutput("refetch_addr",   imemBus.imemAddr, 32'h90);
    checkOutput("refetch_halted", 32'(halted), 32'd0);
    checkOutput("refetch_fault",  32'(fault), 32'd1);

    // Ack arriving on the limit cycle wins over the timeout
    repeat (15) applyStimulus(0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    applyStimulus(0, 0, 0, 0, 32'h0, 0, 32'h0, 1, 32'hD000_0000);
    checkOutput("lim_valid",  32'(instrValid), 32'd1);
    checkOutput("lim_halted", 32'(halted), 32'd0);
    checkOutput("lim_instr",  instr, 32'hD000_0000);

    // PC wrap at the top of the address space, then halt advances PC
    applyStimulus(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0, 0, 32'h0);
    checkOutput("top_pc",     pcOut, 32'hFFFF_FFFC);
    checkOutput("top_retire", retireCount, 32'd8);
    applyStimulus(0, 0, 0, 0, 32'h0, 0, 32'h0, 1, 32'hE000_0000);
    applyStimulus(0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    checkOutput("wrap_pc",     pcOut, 32'h0);
    checkOutput("wrap_retire", retireCount, 32'd9);
    applyStimulus(0, 0, 0, 0, 32'h0, 0, 32'h0, 1, 32'hE000_0001);
    applyStimulus(0, 0, 1, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    checkOutput("halt_halted", 32'(halted), 32'd1);
    checkOutput("halt_pc",     pcOut, 32'h4);
    checkOutput("halt_retire", retireCount, 32'd10);
    checkOutput("halt_valid",  32'(instrValid), 32'd0);
    applyStimulus(0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    checkOutput("halt_hold", 32'(halted), 32'd1);

    // Misaligned branch target: trapped or loaded as given
    applyStimulus(1, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    checkOutput("restart_addr", imemBus.imemAddr, 32'h4);
    applyStimulus(0, 0, 0, 0, 32'h0, 0, 32'h0, 1, 32'hF000_0000);
    applyStimulus(0, 0, 0, 0, 32'h0, 1, 32'h102, 0, 32'h0);
    checkOutput("mis_pc",     pcOut, expTrapPc);
    checkOutput("mis_trap",   32'(trap), 32'(expTrap));
    checkOutput("mis_retire", retireCount, 32'd11);
    applyStimulus(0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    checkOutput("mis_trap_end", 32'(trap), 32'd0);
    checkOutput("mis_req",      32'(imemBus.imemReq), 32'd1);

    // Reset asserted mid-fetch clears everything before the next edge
    #2 rstN = 1'b0;
    #1;
    checkOutput("midrst_req",    32'(imemBus.imemReq), 32'd0);
    checkOutput("midrst_pc",     pcOut, 32'h0);
    checkOutput("midrst_fault",  32'(fault), 32'd0);
    checkOutput("midrst_retire", retireCount, 32'd0);
    #5 rstN = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
